// File: rtl/scaled_add_seq_pkg.sv
// Shared types and helpers for the scaled_add_seq block.
// Holds the controller state encoding and the step-counter width helper.
// No logic; imported by the datapath and the top.
package scaled_add_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter must hold the value MUL_WIDTH itself, hence the +1.
  function automatic int cnt_width(input int mul_width);
    return (mul_width < 1) ? 1 : $clog2(mul_width + 1);
  endfunction

endpackage

// File: rtl/scaled_add_seq_if.sv
// Request/response bundle for scaled_add_seq: operands in, scaled sum out.
// Ports: req_valid/req_ready + a/m/b/sat (request), resp_valid/resp_ready + out/ovf (response).
// master = requester/consumer side, slave = the arithmetic block.
interface scaled_add_seq_if #(
  parameter int WIDTH     = 8,
  parameter int MUL_WIDTH = 2
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     a;
  logic [MUL_WIDTH-1:0] m;
  logic [WIDTH-1:0]     b;
  logic                 sat;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WIDTH-1:0]     out;
  logic                 ovf;

  modport master (
    output req_valid, a, m, b, sat, resp_ready,
    input  req_ready, resp_valid, out, ovf
  );

  modport slave (
    input  req_valid, a, m, b, sat, resp_ready,
    output req_ready, resp_valid, out, ovf
  );

endinterface

// File: rtl/scaled_add_seq_full_adder.sv
// Purpose: N-bit unsigned adder with carry in/out, shared by every accumulate step.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: a_i, b_i, cin_i -> sum_o, cout_o.
module scaled_add_seq_full_adder #(
  parameter int N = 11
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/scaled_add_seq.sv
// Purpose: OUT = A*M + B by shift-and-add, one multiplier bit per cycle, optional saturation.
// Latency: accept at edge N, result valid after edge N+MUL_WIDTH, independent of data.
// Backpressure: result held in DONE until resp_ready; no new request accepted until back in IDLE.
// Ports: clk_i, n_rst_i (synchronous, active low), bus (slave side of scaled_add_seq_if).
module scaled_add_seq
  import scaled_add_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MUL_WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  scaled_add_seq_if.slave  bus
);

  // One spare bit above WIDTH+MUL_WIDTH so the largest A*M+B never wraps.
  localparam int ACC_W = WIDTH + MUL_WIDTH + 1;
  localparam int MC_W  = WIDTH + MUL_WIDTH;
  localparam int CNT_W = cnt_width(MUL_WIDTH);

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [MC_W-1:0]      mcand_q, mcand_d;
  logic [MUL_WIDTH-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_W-1:0]     add_sum;
  logic                 add_cout_unused; // accumulator is sized so this never sets

  scaled_add_seq_full_adder #(
    .N (ACC_W)
  ) u_add (
    .a_i    (acc_q),
    .b_i    ({1'b0, mcand_q}),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout_unused)
  );

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    out_d   = out_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          acc_d   = ACC_W'(bus.b);
          mcand_d = MC_W'(bus.a);
          mplr_d  = bus.m;
          sat_d   = bus.sat;
          cnt_d   = CNT_W'(MUL_WIDTH);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (mplr_q[0]) begin
          acc_d = add_sum;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q - CNT_W'(1);
        // Last step: fold the final accumulator into the registered result now,
        // so OUT/OVF are already valid on the first DONE cycle.
        if (cnt_q == CNT_W'(1)) begin
          ovf_d   = |acc_d[ACC_W-1:WIDTH];
          out_d   = (sat_q && ovf_d) ? {WIDTH{1'b1}} : acc_d[WIDTH-1:0];
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.out        = out_q;
  assign bus.ovf        = ovf_q;

`ifdef FORMAL
  // Shadow copies of the accepted operands; the working registers are shifted away.
  logic [WIDTH-1:0]     f_a_q, f_b_q;
  logic [MUL_WIDTH-1:0] f_m_q;
  logic [ACC_W-1:0]     f_full;

  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && bus.req_valid) begin
      f_a_q <= bus.a;
      f_b_q <= bus.b;
      f_m_q <= bus.m;
    end
  end

  assign f_full = ACC_W'(f_a_q) * ACC_W'(f_m_q) + ACC_W'(f_b_q);

  always_comb begin
    if (state_q == S_DONE) begin
      assert (ovf_q == (|f_full[ACC_W-1:WIDTH]));
      assert (out_q == ((sat_q && ovf_q) ? {WIDTH{1'b1}} : f_full[WIDTH-1:0]));
    end
    assert (!(bus.req_ready && bus.resp_valid));
  end
`endif

endmodule

// File: tb/tb_scaled_add_seq.sv
module tb_scaled_add_seq;

  typedef struct {
    logic [15:0] out;
    logic        ovf;
  } exp_t;

  logic clk;
  logic n_rst;
  int   total;
  int   bad;
  exp_t q8[$];
  exp_t q16[$];

  scaled_add_seq_if #(.WIDTH(8),  .MUL_WIDTH(2)) bus8  ();
  scaled_add_seq_if #(.WIDTH(16), .MUL_WIDTH(4)) bus16 ();

  scaled_add_seq #(.WIDTH(8),  .MUL_WIDTH(2)) dut8  (.clk_i(clk), .n_rst_i(n_rst), .bus(bus8));
  scaled_add_seq #(.WIDTH(16), .MUL_WIDTH(4)) dut16 (.clk_i(clk), .n_rst_i(n_rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-precision A*M+B, then wrap or saturate to w bits.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [3:0] m,
                                 input logic [15:0] b, input logic sat);
    exp_t   r;
    longint full;
    longint mask;
    full  = longint'(a) * longint'(m) + longint'(b);
    mask  = (longint'(1) << w) - 1;
    r.ovf = (full > mask);
    r.out = (sat && r.ovf) ? 16'(mask) : 16'(full & mask);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request to the 8-bit unit (starting in IDLE) and check latency and result.
  // Leaves the unit in DONE with resp_ready low.
  task automatic op8(input logic [7:0] a, input logic [1:0] m, input logic [7:0] b, input logic sat);
    exp_t e;
    @(negedge clk);
    bus8.a = a; bus8.m = m; bus8.b = b; bus8.sat = sat;
    bus8.req_valid = 1'b1;
    q8.push_back(model(8, 16'(a), 4'(m), 16'(b), sat));
    @(negedge clk);
    check("accept_rdy_low", 32'(bus8.req_ready), 32'd0);
    bus8.req_valid = 1'b0;
    // Scramble operands during RUN; they must be ignored.
    bus8.a = ~a; bus8.m = ~m; bus8.b = ~b; bus8.sat = ~sat;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("lat8_valid", 32'(bus8.resp_valid), 32'(k == 2));
    end
    if (q8.size() == 0) begin
      check("sb8_empty", 32'd1, 32'd0);
    end else begin
      e = q8.pop_front();
      check("out8", 32'(bus8.out), 32'(e.out[7:0]));
      check("ovf8", 32'(bus8.ovf), 32'(e.ovf));
    end
  endtask

  task automatic finish8();
    bus8.resp_ready = 1'b1;
    @(negedge clk);
    bus8.resp_ready = 1'b0;
    check("idle8_valid", 32'(bus8.resp_valid), 32'd0);
    check("idle8_ready", 32'(bus8.req_ready), 32'd1);
  endtask

  logic [15:0] ra[16];
  logic [3:0]  rm[16];
  logic [15:0] rb[16];
  logic        rs[16];

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    bus8.req_valid  = 1'b0; bus8.a  = '0; bus8.m  = '0; bus8.b  = '0; bus8.sat  = 1'b0; bus8.resp_ready  = 1'b0;
    bus16.req_valid = 1'b0; bus16.a = '0; bus16.m = '0; bus16.b = '0; bus16.sat = 1'b0; bus16.resp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst8_ready", 32'(bus8.req_ready), 32'd1);
    check("rst8_valid", 32'(bus8.resp_valid), 32'd0);
    check("rst8_out", 32'(bus8.out), 32'd0);
    check("rst8_ovf", 32'(bus8.ovf), 32'd0);
    check("rst16_ready", 32'(bus16.req_ready), 32'd1);
    check("rst16_valid", 32'(bus16.resp_valid), 32'd0);
    n_rst = 1'b1;

    // Directed cases: legacy 2A+B, wrap, saturate, zero multiplier
    op8(8'h10, 2'd2, 8'h05, 1'b0); finish8();
    op8(8'hFF, 2'd3, 8'hFF, 1'b0); finish8();
    op8(8'hFF, 2'd3, 8'hFF, 1'b1); finish8();
    op8(8'hAB, 2'd0, 8'h12, 1'b0); finish8();

    // Backpressure: result held for 5 cycles, stray request ignored
    op8(8'h7F, 2'd3, 8'h40, 1'b1);
    e = model(8, 16'h007F, 4'd3, 16'h0040, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus8.a = 8'h01; bus8.m = 2'd1; bus8.b = 8'h01; bus8.sat = 1'b0;
        bus8.req_valid = 1'b1;
      end
      @(negedge clk);
      bus8.req_valid = 1'b0;
      check("bp_valid", 32'(bus8.resp_valid), 32'd1);
      check("bp_ready", 32'(bus8.req_ready), 32'd0);
      check("bp_out", 32'(bus8.out), 32'(e.out[7:0]));
      check("bp_ovf", 32'(bus8.ovf), 32'(e.ovf));
    end
    finish8();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_no_stray", 32'(bus8.resp_valid), 32'd0);
    end

    // Reset during RUN discards the operation
    @(negedge clk);
    bus8.a = 8'h33; bus8.m = 2'd3; bus8.b = 8'h01; bus8.sat = 1'b0;
    bus8.req_valid = 1'b1;
    @(negedge clk);
    bus8.req_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    check("midrst_ready", 32'(bus8.req_ready), 32'd1);
    check("midrst_valid", 32'(bus8.resp_valid), 32'd0);
    check("midrst_out", 32'(bus8.out), 32'd0);
    check("midrst_ovf", 32'(bus8.ovf), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(bus8.resp_valid), 32'd0);
    end
    op8(8'h20, 2'd1, 8'h03, 1'b0); finish8();

    // 16-bit, back-to-back random requests with resp_ready held high
    for (int i = 0; i < 16; i++) begin
      ra[i] = 16'($urandom);
      rm[i] = 4'($urandom);
      rb[i] = 16'($urandom);
      rs[i] = 1'($urandom);
    end
    ra[0] = 16'hFFFF; rm[0] = 4'hF; rb[0] = 16'hFFFF; rs[0] = 1'b0;
    rm[1] = 4'h0;
    bus16.resp_ready = 1'b1;
    @(negedge clk);
    bus16.a = ra[0]; bus16.m = rm[0]; bus16.b = rb[0]; bus16.sat = rs[0];
    bus16.req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      q16.push_back(model(16, ra[i], rm[i], rb[i], rs[i]));
      @(negedge clk);
      check("b2b_accept", 32'(bus16.req_ready), 32'd0);
      if (i < 15) begin
        bus16.a = ra[i+1]; bus16.m = rm[i+1]; bus16.b = rb[i+1]; bus16.sat = rs[i+1];
      end else begin
        bus16.req_valid = 1'b0;
      end
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        check("lat16_valid", 32'(bus16.resp_valid), 32'(k == 4));
      end
      check("done16_ready", 32'(bus16.req_ready), 32'd0);
      if (q16.size() == 0) begin
        check("sb16_empty", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        check("out16", 32'(bus16.out), 32'(e.out));
        check("ovf16", 32'(bus16.ovf), 32'(e.ovf));
      end
      @(negedge clk);
      check("gap16_ready", 32'(bus16.req_ready), 32'd1);
      check("gap16_valid", 32'(bus16.resp_valid), 32'd0);
    end
    bus16.resp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
